ucq_arbiter: RTL and testbench
==============================

UCQ_ARBITER -- requirements
Module: ucq_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_PE, default 4, meaning the number of BCP engines served.
REQ-002 The module SHALL have parameter UCQ_DEPTH, default 8 (power of two), meaning the unit-clause queue entry count.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-high (asserted = 1) despite the name.
REQ-005 dec_lit / dec_lit_valid / dec_lit_ready  input lit_t / input 1 / output 1  decision literal push from the decision unit.
REQ-006 ucarb2bcp_newLit  output  lit_t  literal broadcast to all engines.
REQ-007 ucarb2bcp_newLitValid  output  NUM_PE  per-engine valid.
REQ-008 bcp2ucarb_newLitAccept  input  NUM_PE  per-engine accept.
REQ-009 imply_valid / imply_lit  input NUM_PE / input lit_t[NUM_PE]  per-engine implication.
REQ-010 conflict  input  NUM_PE  per-engine conflict.
REQ-011 halt  input  1  stall from clause arbiter.
REQ-012 conflict_out  output  1  one-cycle conflict pulse to decision unit.
REQ-013 conflict_ack  input  1  decision unit releases conflict state.
REQ-014 quiescent  output  1  queue empty, state UA_IDLE, no implication this cycle.
REQ-015 ucq_overflow  output  1  sticky implication-drop error.

Function
REQ-016 States SHALL be UA_IDLE (no literal outstanding), UA_BCAST (literal outstanding), UA_CONFLICT (flushed, waiting conflict_ack).
REQ-017 Per engine i, transfer SHALL occur when newLitValid[i] && newLitAccept[i] && !halt; a per-engine done mask records transfers.
REQ-018 UA_IDLE with non-empty queue SHALL pop the head into an output register and enter UA_BCAST next cycle, all valid bits set.
REQ-019 In UA_BCAST newLitValid[i] SHALL be 1 exactly while done[i]=0; when all done bits are set, return to UA_IDLE (or pop next head immediately if non-empty, no bubble).
REQ-020 dec_lit_ready SHALL be 1 only when quiescent=1; an accepted dec_lit is enqueued.
REQ-021 All asserted imply_valid in one cycle SHALL be enqueued in ascending engine index, a literal equal to a lower-index same-cycle implication being dropped.
REQ-022 If free entries are fewer than surviving implications, the lowest-index ones SHALL be enqueued, the rest dropped, and ucq_overflow set until reset.
REQ-023 Any conflict bit (ignored while halt=1) SHALL, next cycle: flush queue, clear valids, pulse conflict_out once, enter UA_CONFLICT; conflict beats same-cycle implications (not enqueued).
REQ-024 UA_CONFLICT SHALL ignore implications and dec_lit and exit to UA_IDLE on conflict_ack.
REQ-025 halt=1 SHALL freeze state, queue, and done mask; implications still enqueue.
REQ-026 Queue pointers SHALL wrap modulo UCQ_DEPTH with an extra wrap bit distinguishing full from empty; simultaneous pop and push on a full queue SHALL be legal.

Reset
REQ-027 On rst_n: state UA_IDLE, queue empty, done mask 0, newLitValid 0, newLit 0, conflict_out 0, ucq_overflow 0, dec_lit_ready 0 until the first post-reset cycle; reset mid-broadcast discards the literal.

Configuration
REQ-028 With UCQ_DEDUP_EN defined, an implication matching any queued or outstanding literal SHALL be dropped, and one matching its negation SHALL be treated as a conflict (REQ-023); without it, only same-cycle dedup (REQ-021) applies.

Structure
REQ-029 lit_t, ucarb_state_t, and UCQ_DEPTH default SHALL live in the shared package alongside bcp_state_t.
REQ-030 The queue SHALL be a sub-module ucq_fifo (multi-push, single-pop, flush).

Verification
REQ-031 NUM_PE=2: dec_lit=5 pushed, engine0 accepts cycle 1, engine1 cycle 3 -> valid[0] drops after cycle 1, valid[1] after cycle 3, state UA_IDLE cycle 4.
REQ-032 imply (3,3) same cycle -> one entry 3 enqueued.
REQ-033 UCQ_DEPTH=4 with 3 entries, imply (7,-2) -> 7 enqueued, -2 dropped, ucq_overflow=1.
REQ-034 conflict[1]=1 with 2 entries queued and imply 9 -> queue empty, conflict_out one cycle, 9 absent; conflict_ack -> UA_IDLE, quiescent=1.
REQ-035 halt=1 during UA_BCAST with accepts high -> no transfers, mask unchanged; halt=0 -> transfers complete.
REQ-036 UCQ_DEDUP_EN: queue holds 4, imply -4 -> conflict_out pulse; imply 4 -> dropped.

Source files
------------

// File: rtl/ucq_arbiter_pkg.sv
// ucq_arbiter_pkg -- shared types for the BCP front end.
//   lit_t          : signed literal (negative value = negated variable)
//   ucarb_state_t  : unit-clause arbiter state encoding (UA_* constants)
//   bcp_state_t    : BCP engine state, shared with the engine side
//   UCQ_DEPTH_DEFAULT : default unit-clause queue depth
package ucq_arbiter_pkg;

  localparam int LIT_W             = 16;
  localparam int UCQ_DEPTH_DEFAULT = 8;

  typedef logic signed [LIT_W-1:0] lit_t;

  typedef logic [1:0] ucarb_state_t;
  localparam ucarb_state_t UA_IDLE     = 2'd0;  // nothing outstanding
  localparam ucarb_state_t UA_BCAST    = 2'd1;  // literal being broadcast
  localparam ucarb_state_t UA_CONFLICT = 2'd2;  // flushed, waiting for ack

  typedef enum logic [1:0] {
    BCP_IDLE,
    BCP_PROPAGATE,
    BCP_CONFLICT
  } bcp_state_t;

  function automatic lit_t lit_neg(input lit_t l);
    return -l;
  endfunction

endpackage

// File: rtl/ucq_fifo.sv
// ucq_fifo -- unit-clause queue: up to NPUSH pushes per cycle, one pop, flush.
// Ports:
//   clk, rst_n        : clock, asynchronous active-high reset
//   flush             : drop every entry (wins over push/pop)
//   push_valid/data   : push slots, written in ascending slot order
//   pop               : remove head (ignored when empty)
//   head, empty, count: queue status; head is valid when !empty
//   entries_flat      : raw storage, entry k at [k*LIT_W +: LIT_W]
//   occupied          : per storage slot, 1 when it holds a queued entry
// The caller must never present more pushes than free entries (pop counts
// as freeing one entry in the same cycle).
module ucq_fifo
  import ucq_arbiter_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NPUSH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [NPUSH-1:0]       push_valid,
  input  lit_t                   push_data [NPUSH],
  input  logic                   pop,
  output lit_t                   head,
  output logic                   empty,
  output logic [AW:0]            count,
  output logic [DEPTH*LIT_W-1:0] entries_flat,
  output logic [DEPTH-1:0]       occupied
);

  lit_t          mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [AW:0]   push_cnt;
  logic [AW-1:0] waddr [NPUSH];

  // Compact the valid push slots onto consecutive entries after wr_ptr.
  always_comb begin
    push_cnt = '0;
    for (int i = 0; i < NPUSH; i++) begin
      waddr[i] = wr_ptr_reg[AW-1:0] + push_cnt[AW-1:0];
      push_cnt = push_cnt + (AW+1)'(push_valid[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < NPUSH; i++) begin
        if (push_valid[i]) mem[waddr[i]] <= push_data[i];
      end
    end
  end

  // The extra MSB on each pointer tells full (MSBs differ) from empty.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      rd_ptr_reg <= wr_ptr_reg;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + push_cnt;
      if (pop && !empty) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign head  = mem[rd_ptr_reg[AW-1:0]];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [AW-1:0] rel;
      assign rel = AW'(gi) - rd_ptr_reg[AW-1:0];
      assign occupied[gi] = ({1'b0, rel} < count);
      assign entries_flat[gi*LIT_W +: LIT_W] = mem[gi];
    end
  endgenerate

endmodule

// File: rtl/ucq_arbiter.sv
// ucq_arbiter -- unit-clause queue arbiter feeding NUM_PE BCP engines.
// Queues decision literals and engine implications, broadcasts one literal
// at a time to every engine and waits until each has accepted it; any engine
// conflict flushes everything and waits for the decision unit's ack.
// Ports:
//   clk, rst_n                 : clock; rst_n is asynchronous ACTIVE-HIGH
//   dec_lit/_valid/_ready      : decision literal push (only when quiescent)
//   ucarb2bcp_newLit/Valid     : broadcast literal, per-engine valid
//   bcp2ucarb_newLitAccept     : per-engine accept
//   imply_valid/imply_lit      : per-engine implications
//   conflict                   : per-engine conflict
//   halt                       : freezes state/queue/done mask
//   conflict_out, conflict_ack : conflict pulse and release
//   quiescent, ucq_overflow    : idle indication, sticky drop error
// Build option: UCQ_DEDUP_EN -- drop implications already queued or
// outstanding, and treat an implication of a negated queued/outstanding
// literal as a conflict.
module ucq_arbiter
  import ucq_arbiter_pkg::*;
#(
  parameter int NUM_PE    = 4,
  parameter int UCQ_DEPTH = UCQ_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  lit_t              dec_lit,
  input  logic              dec_lit_valid,
  output logic              dec_lit_ready,
  output lit_t              ucarb2bcp_newLit,
  output logic [NUM_PE-1:0] ucarb2bcp_newLitValid,
  input  logic [NUM_PE-1:0] bcp2ucarb_newLitAccept,
  input  logic [NUM_PE-1:0] imply_valid,
  input  lit_t              imply_lit [NUM_PE],
  input  logic [NUM_PE-1:0] conflict,
  input  logic              halt,
  output logic              conflict_out,
  input  logic              conflict_ack,
  output logic              quiescent,
  output logic              ucq_overflow
);

  localparam int AW = $clog2(UCQ_DEPTH);

  ucarb_state_t      state_reg;
  lit_t              new_lit_reg;
  logic [NUM_PE-1:0] done_reg;
  logic              conflict_out_reg;
  logic              overflow_reg;

  lit_t                      fifo_head;
  logic                      fifo_empty;
  logic [AW:0]               fifo_count;
  logic [UCQ_DEPTH*LIT_W-1:0] entries_flat;
  logic [UCQ_DEPTH-1:0]      occupied;

  logic [NUM_PE-1:0] lit_valid, xfer, done_merged;
  logic              bcast_done;
  logic [NUM_PE-1:0] same_dup, hit_dup, hit_neg;
  logic [NUM_PE-1:0] imply_live, survive, keep, push_valid;
  lit_t              push_data [NUM_PE];
  logic              neg_conflict, conflict_fire, pop, dropped, dec_push;
  logic [AW:0]       free_slots;
  int                rank;

  assign lit_valid   = (state_reg == UA_BCAST) ? ~done_reg : '0;
  assign xfer        = lit_valid & bcp2ucarb_newLitAccept & {NUM_PE{~halt}};
  assign done_merged = done_reg | xfer;
  assign bcast_done  = (state_reg == UA_BCAST) && (&done_merged);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_pe
      // Same-cycle duplicate: a lower-index engine implies the same literal.
      logic dup_l;
      always_comb begin
        dup_l = 1'b0;
        for (int j = 0; j < gi; j++) begin
          if (imply_valid[j] && (imply_lit[j] == imply_lit[gi])) dup_l = 1'b1;
        end
      end
      assign same_dup[gi] = dup_l;

`ifdef UCQ_DEDUP_EN
      logic hit_l, neg_l;
      lit_t ent;
      always_comb begin
        hit_l = 1'b0;
        neg_l = 1'b0;
        ent   = '0;
        if (state_reg == UA_BCAST) begin
          if (new_lit_reg == imply_lit[gi]) hit_l = 1'b1;
          if (new_lit_reg == lit_neg(imply_lit[gi])) neg_l = 1'b1;
        end
        for (int k = 0; k < UCQ_DEPTH; k++) begin
          ent = entries_flat[k*LIT_W +: LIT_W];
          if (occupied[k]) begin
            if (ent == imply_lit[gi]) hit_l = 1'b1;
            if (ent == lit_neg(imply_lit[gi])) neg_l = 1'b1;
          end
        end
      end
      assign hit_dup[gi] = hit_l;
      assign hit_neg[gi] = neg_l;
`else
      assign hit_dup[gi] = 1'b0;
      assign hit_neg[gi] = 1'b0;
`endif

      // Slot 0 doubles as the decision-literal push: decisions are only
      // accepted while no implication is present.
      if (gi == 0) begin : g_slot0
        assign push_data[gi] = dec_push ? dec_lit : imply_lit[gi];
      end else begin : g_slotn
        assign push_data[gi] = imply_lit[gi];
      end
    end
  endgenerate

`ifndef UCQ_DEDUP_EN
  logic unused_dedup;
  assign unused_dedup = ^{occupied, entries_flat};
`endif

  assign imply_live    = imply_valid & {NUM_PE{state_reg != UA_CONFLICT}};
  assign neg_conflict  = |(imply_live & hit_neg);
  assign conflict_fire = (state_reg != UA_CONFLICT) && !halt &&
                         ((|conflict) || neg_conflict);
  assign survive       = imply_live & ~same_dup & ~hit_dup & ~hit_neg &
                         {NUM_PE{~conflict_fire}};

  assign pop = !halt && !conflict_fire && !fifo_empty &&
               ((state_reg == UA_IDLE) || bcast_done);

  // The entry popped this cycle is reusable by this cycle's pushes.
  assign free_slots = (AW+1)'(UCQ_DEPTH) - fifo_count + (AW+1)'(pop);

  always_comb begin
    keep = '0;
    rank = 0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (survive[i]) begin
        if (rank < int'(free_slots)) keep[i] = 1'b1;
        rank = rank + 1;
      end
    end
  end

  assign dropped    = |(survive & ~keep);
  assign quiescent  = fifo_empty && (state_reg == UA_IDLE) && !(|imply_valid);
  assign dec_lit_ready = quiescent && !rst_n;
  assign dec_push   = dec_lit_valid && dec_lit_ready && !conflict_fire;
  assign push_valid = keep | NUM_PE'(dec_push);

  ucq_fifo #(
    .DEPTH (UCQ_DEPTH),
    .NPUSH (NUM_PE)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (conflict_fire),
    .push_valid   (push_valid),
    .push_data    (push_data),
    .pop          (pop),
    .head         (fifo_head),
    .empty        (fifo_empty),
    .count        (fifo_count),
    .entries_flat (entries_flat),
    .occupied     (occupied)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_reg        <= UA_IDLE;
      new_lit_reg      <= '0;
      done_reg         <= '0;
      conflict_out_reg <= 1'b0;
      overflow_reg     <= 1'b0;
    end else begin
      conflict_out_reg <= conflict_fire;
      if (dropped) overflow_reg <= 1'b1;
      if (conflict_fire) begin
        state_reg <= UA_CONFLICT;
        done_reg  <= '0;
      end else if (!halt) begin
        case (state_reg)
          UA_IDLE: begin
            if (pop) begin
              new_lit_reg <= fifo_head;
              done_reg    <= '0;
              state_reg   <= UA_BCAST;
            end
          end
          UA_BCAST: begin
            if (bcast_done) begin
              done_reg <= '0;
              // Next head goes out back-to-back with no idle cycle.
              if (pop) new_lit_reg <= fifo_head;
              else     state_reg   <= UA_IDLE;
            end else begin
              done_reg <= done_merged;
            end
          end
          UA_CONFLICT: begin
            if (conflict_ack) state_reg <= UA_IDLE;
          end
          default: state_reg <= UA_IDLE;
        endcase
      end
    end
  end

  assign ucarb2bcp_newLit      = new_lit_reg;
  assign ucarb2bcp_newLitValid = lit_valid;
  assign conflict_out          = conflict_out_reg;
  assign ucq_overflow          = overflow_reg;

endmodule

// File: tb/tb_ucq_arbiter.sv
// tb_ucq_arbiter -- directed self-checking bench for ucq_arbiter
// (NUM_PE=2, UCQ_DEPTH=4). Inputs change just after the rising edge or at
// the falling edge; outputs are sampled on the falling edge.
module tb_ucq_arbiter;
  import ucq_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  lit_t       dec_lit;
  logic       dec_lit_valid;
  logic       dec_lit_ready;
  lit_t       new_lit;
  logic [1:0] new_lit_valid;
  logic [1:0] accept;
  logic [1:0] imply_valid;
  lit_t       imply_lit [2];
  logic [1:0] conflict;
  logic       halt;
  logic       conflict_out;
  logic       conflict_ack;
  logic       quiescent;
  logic       ucq_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ucq_arbiter #(.NUM_PE(2), .UCQ_DEPTH(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .dec_lit                (dec_lit),
    .dec_lit_valid          (dec_lit_valid),
    .dec_lit_ready          (dec_lit_ready),
    .ucarb2bcp_newLit       (new_lit),
    .ucarb2bcp_newLitValid  (new_lit_valid),
    .bcp2ucarb_newLitAccept (accept),
    .imply_valid            (imply_valid),
    .imply_lit              (imply_lit),
    .conflict               (conflict),
    .halt                   (halt),
    .conflict_out           (conflict_out),
    .conflict_ack           (conflict_ack),
    .quiescent              (quiescent),
    .ucq_overflow           (ucq_overflow)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dec_lit = '0; dec_lit_valid = 1'b0; accept = '0; imply_valid = '0;
    imply_lit[0] = '0; imply_lit[1] = '0; conflict = '0; halt = 1'b0;
    conflict_ack = 1'b0;
  endtask

  task automatic imply1(input int v);
    imply_valid = 2'b01; imply_lit[0] = lit_t'(v);
    cyc();
    imply_valid = '0;
  endtask

  // Waits (bounded) for a broadcast, accepts it on all engines.
  task automatic drain(output lit_t got, output bit ok);
    ok = 1'b0; got = '0;
    for (int k = 0; k < 12 && !ok; k++) begin
      @(negedge clk);
      if (new_lit_valid != 2'b00) begin
        got = new_lit; ok = 1'b1; accept = 2'b11;
      end
      cyc();
      accept = '0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    idle_inputs();
    cyc(); cyc();
    @(negedge clk);
    n_checks++; if (dec_lit_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b expected 0", dec_lit_ready); end
    n_checks++; if (new_lit_valid !== 2'b00) begin n_fail++; $display("FAIL rst_valid: got %b expected 00", new_lit_valid); end
    n_checks++; if (new_lit !== 16'sd0) begin n_fail++; $display("FAIL rst_lit: got %0d expected 0", new_lit); end
    n_checks++; if (conflict_out !== 1'b0) begin n_fail++; $display("FAIL rst_conflict_out: got %0b expected 0", conflict_out); end
    n_checks++; if (ucq_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b expected 0", ucq_overflow); end
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (dec_lit_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %0b expected 1", dec_lit_ready); end
    n_checks++; if (quiescent !== 1'b1) begin n_fail++; $display("FAIL post_rst_quiescent: got %0b expected 1", quiescent); end
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_broadcast();
    dec_lit = 16'sd5; dec_lit_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (dec_lit_ready !== 1'b1) begin n_fail++; $display("FAIL bc_ready: got %0b expected 1", dec_lit_ready); end
    cyc();
    dec_lit_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b00) begin n_fail++; $display("FAIL bc_pre_valid: got %b expected 00", new_lit_valid); end
    cyc();
    accept = 2'b01;                     // broadcast cycle 1
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b11) begin n_fail++; $display("FAIL bc_c1_valid: got %b expected 11", new_lit_valid); end
    n_checks++; if (new_lit !== 16'sd5) begin n_fail++; $display("FAIL bc_c1_lit: got %0d expected 5", new_lit); end
    cyc();
    accept = 2'b00;                     // cycle 2
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b10) begin n_fail++; $display("FAIL bc_c2_valid: got %b expected 10", new_lit_valid); end
    cyc();
    accept = 2'b10;                     // cycle 3
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b10) begin n_fail++; $display("FAIL bc_c3_valid: got %b expected 10", new_lit_valid); end
    cyc();
    accept = 2'b00;                     // cycle 4
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b00) begin n_fail++; $display("FAIL bc_c4_valid: got %b expected 00", new_lit_valid); end
    n_checks++; if (quiescent !== 1'b1) begin n_fail++; $display("FAIL bc_c4_idle: got %0b expected 1", quiescent); end
    cyc();
    $display("test_broadcast done");
  endtask

  task automatic test_same_cycle_dedup();
    lit_t got; bit ok;
    imply_valid = 2'b11; imply_lit[0] = 16'sd3; imply_lit[1] = 16'sd3;
    cyc();
    imply_valid = '0;
    drain(got, ok);
    n_checks++; if (!ok || got !== 16'sd3) begin n_fail++; $display("FAIL dup_first: got %0d (seen %0b) expected 3", got, ok); end
    drain(got, ok);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL dup_second: got literal %0d expected none", got); end
    $display("test_same_cycle_dedup done");
  endtask

  task automatic test_pop_push_full();
    lit_t got; bit ok;
    halt = 1'b1;
    for (int v = 31; v <= 34; v++) imply1(v);
    halt = 1'b0; imply_valid = 2'b01; imply_lit[0] = 16'sd35;
    cyc();
    imply_valid = '0;
    @(negedge clk);
    n_checks++; if (ucq_overflow !== 1'b0) begin n_fail++; $display("FAIL full_overflow: got %0b expected 0", ucq_overflow); end
    cyc();
    for (int v = 31; v <= 35; v++) begin
      drain(got, ok);
      n_checks++; if (!ok || got !== lit_t'(v)) begin n_fail++; $display("FAIL full_drain: got %0d (seen %0b) expected %0d", got, ok, v); end
    end
    $display("test_pop_push_full done");
  endtask

  task automatic test_overflow();
    lit_t got; bit ok;
    halt = 1'b1;
    imply1(1); imply1(2); imply1(6);
    imply_valid = 2'b11; imply_lit[0] = 16'sd7; imply_lit[1] = -16'sd2;
    @(negedge clk);
    n_checks++; if (ucq_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_before: got %0b expected 0", ucq_overflow); end
    cyc();
    imply_valid = '0;
    @(negedge clk);
    n_checks++; if (ucq_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %0b expected 1", ucq_overflow); end
    halt = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      int expv;
      expv = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 6 : 7;
      drain(got, ok);
      n_checks++; if (!ok || got !== lit_t'(expv)) begin n_fail++; $display("FAIL ovf_drain: got %0d (seen %0b) expected %0d", got, ok, expv); end
    end
    drain(got, ok);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped: got literal %0d expected none", got); end
    n_checks++; if (ucq_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", ucq_overflow); end
    $display("test_overflow done");
  endtask

  task automatic test_conflict();
    lit_t got; bit ok;
    halt = 1'b1;
    imply1(11); imply1(12);
    halt = 1'b0; conflict = 2'b10; imply_valid = 2'b01; imply_lit[0] = 16'sd9;
    cyc();
    conflict = '0; imply_valid = '0;
    @(negedge clk);
    n_checks++; if (conflict_out !== 1'b1) begin n_fail++; $display("FAIL cf_pulse: got %0b expected 1", conflict_out); end
    n_checks++; if (new_lit_valid !== 2'b00) begin n_fail++; $display("FAIL cf_valid: got %b expected 00", new_lit_valid); end
    cyc();
    imply_valid = 2'b01; imply_lit[0] = 16'sd13; dec_lit = 16'sd14; dec_lit_valid = 1'b1;
    @(negedge clk);
    n_checks++; if (conflict_out !== 1'b0) begin n_fail++; $display("FAIL cf_one_cycle: got %0b expected 0", conflict_out); end
    n_checks++; if (dec_lit_ready !== 1'b0) begin n_fail++; $display("FAIL cf_ready: got %0b expected 0", dec_lit_ready); end
    cyc();
    imply_valid = '0; dec_lit_valid = 1'b0; conflict_ack = 1'b1;
    @(negedge clk);
    n_checks++; if (quiescent !== 1'b0) begin n_fail++; $display("FAIL cf_wait_ack: got %0b expected 0", quiescent); end
    cyc();
    conflict_ack = 1'b0;
    @(negedge clk);
    n_checks++; if (quiescent !== 1'b1) begin n_fail++; $display("FAIL cf_after_ack: got %0b expected 1", quiescent); end
    cyc();
    drain(got, ok);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL cf_flushed: got literal %0d expected none", got); end
    $display("test_conflict done");
  endtask

  task automatic test_halt();
    dec_lit = 16'sd21; dec_lit_valid = 1'b1;
    cyc();
    dec_lit_valid = 1'b0;
    cyc();
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b11 || new_lit !== 16'sd21) begin n_fail++; $display("FAIL halt_start: got %b/%0d expected 11/21", new_lit_valid, new_lit); end
    halt = 1'b1; accept = 2'b11;
    cyc();
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b11) begin n_fail++; $display("FAIL halt_hold1: got %b expected 11", new_lit_valid); end
    cyc();
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b11) begin n_fail++; $display("FAIL halt_hold2: got %b expected 11", new_lit_valid); end
    halt = 1'b0;
    cyc();
    accept = 2'b00;
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b00) begin n_fail++; $display("FAIL halt_release: got %b expected 00", new_lit_valid); end
    n_checks++; if (quiescent !== 1'b1) begin n_fail++; $display("FAIL halt_idle: got %0b expected 1", quiescent); end
    cyc();
    $display("test_halt done");
  endtask

  task automatic test_reset_mid_broadcast();
    dec_lit = 16'sd40; dec_lit_valid = 1'b1;
    cyc();
    dec_lit_valid = 1'b0;
    cyc();
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got %b expected 11", new_lit_valid); end
    rst_n = 1'b1;
    cyc();
    @(negedge clk);
    n_checks++; if (new_lit_valid !== 2'b00 || new_lit !== 16'sd0) begin n_fail++; $display("FAIL mid_rst: got %b/%0d expected 00/0", new_lit_valid, new_lit); end
    n_checks++; if (ucq_overflow !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ovf: got %0b expected 0", ucq_overflow); end
    rst_n = 1'b0;
    cyc();
    @(negedge clk);
    n_checks++; if (quiescent !== 1'b1 || new_lit_valid !== 2'b00) begin n_fail++; $display("FAIL mid_after: got q=%0b v=%b expected q=1 v=00", quiescent, new_lit_valid); end
    cyc();
    $display("test_reset_mid_broadcast done");
  endtask

`ifdef UCQ_DEDUP_EN
  task automatic test_dedup();
    lit_t got; bit ok;
    halt = 1'b1;
    imply1(4);
    halt = 1'b0; imply_valid = 2'b01; imply_lit[0] = -16'sd4;
    cyc();
    imply_valid = '0;
    @(negedge clk);
    n_checks++; if (conflict_out !== 1'b1) begin n_fail++; $display("FAIL dd_neg_conflict: got %0b expected 1", conflict_out); end
    cyc();
    conflict_ack = 1'b1;
    cyc();
    conflict_ack = 1'b0;
    halt = 1'b1;
    imply1(4); imply1(4);
    halt = 1'b0;
    drain(got, ok);
    n_checks++; if (!ok || got !== 16'sd4) begin n_fail++; $display("FAIL dd_first: got %0d (seen %0b) expected 4", got, ok); end
    drain(got, ok);
    n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL dd_dropped: got literal %0d expected none", got); end
    $display("test_dedup done");
  endtask
`else
  task automatic test_no_dedup();
    lit_t got; bit ok;
    halt = 1'b1;
    imply1(4); imply1(4);
    halt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drain(got, ok);
      n_checks++; if (!ok || got !== 16'sd4) begin n_fail++; $display("FAIL nd_entry: got %0d (seen %0b) expected 4", got, ok); end
    end
    n_checks++; if (conflict_out !== 1'b0) begin n_fail++; $display("FAIL nd_conflict: got %0b expected 0", conflict_out); end
    $display("test_no_dedup done");
  endtask
`endif

  initial begin
    test_reset();
    test_broadcast();
    test_same_cycle_dedup();
    test_pop_push_full();
    test_overflow();
    test_conflict();
    test_halt();
    test_reset_mid_broadcast();
`ifdef UCQ_DEDUP_EN
    test_dedup();
`else
    test_no_dedup();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
